// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the tx drain-FSM state encoding.
// Used by the transmitter, receiver and transmit FIFO.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    D_IDLE   = 2'd0,
    D_LAUNCH = 2'd1,
    D_WAIT   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side and transmitter-side signals of the UART transmit FIFO.
// Overflow signals exist only with UART_TX_FIFO_OVERFLOW_EN defined.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_en;
  logic                   flush;
  logic                   full;
  logic                   empty;
  logic [ADDR_W:0]        level;
  logic [UART_DATA_W-1:0] tx_din;
  logic                   tx_wr_en;
  logic                   tx_busy;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic                   overflow;
  logic                   overflow_clr;
`endif

  modport master (
    output wr_data, wr_en, flush, tx_busy,
`ifdef UART_TX_FIFO_OVERFLOW_EN
    output overflow_clr,
    input  overflow,
`endif
    input  full, empty, level, tx_din, tx_wr_en
  );

  modport slave (
    input  wr_data, wr_en, flush, tx_busy,
`ifdef UART_TX_FIFO_OVERFLOW_EN
    input  overflow_clr,
    output overflow,
`endif
    output full, empty, level, tx_din, tx_wr_en
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage: synchronous write, asynchronous read.
// No reset on the array so it maps onto distributed RAM.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     waddr,
  input  logic [UART_DATA_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  output logic [UART_DATA_W-1:0]       rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART transmitter via wr_en/tx_busy.
// Optional sticky overflow flag: define UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];

  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [ADDR_W:0]        level;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic [UART_DATA_W-1:0] rd_data;
  logic [UART_DATA_W-1:0] tx_din_q;
  logic                   tx_wr_en_q;
  logic                   tx_wr_en_nx;
  drain_state_t           state;
  drain_state_t           state_nx;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign push  = bus.wr_en && !full && !bus.flush;

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // pointers and fill level; flush empties the queue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
    end
  end

  // drain state, launch strobe and presented byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= D_IDLE;
      tx_wr_en_q <= 1'b0;
      tx_din_q   <= '0;
    end else begin
      state      <= state_nx;
      tx_wr_en_q <= tx_wr_en_nx;
      if (pop) tx_din_q <= rd_data;
    end
  end

  // drain next-state: launch one byte, then wait out the frame
  always_comb begin
    state_nx    = state;
    tx_wr_en_nx = 1'b0;
    pop         = 1'b0;
    unique case (state)
      D_IDLE: begin
        if (!empty && !bus.tx_busy && !bus.flush) begin
          pop         = 1'b1;
          tx_wr_en_nx = 1'b1;
          state_nx    = D_LAUNCH;
        end
      end
      D_LAUNCH: state_nx = D_WAIT;
      D_WAIT: begin
        if (!bus.tx_busy) state_nx = D_IDLE;
      end
      default: state_nx = D_IDLE;
    endcase
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.tx_din   = tx_din_q;
  assign bus.tx_wr_en = tx_wr_en_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q;

  // sticky record of pushes dropped while full; set beats clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overflow_q <= 1'b0;
    else if (bus.wr_en && full)
      overflow_q <= 1'b1;
    else if (bus.overflow_clr)
      overflow_q <= 1'b0;
  end

  assign bus.overflow = overflow_q;
`endif

endmodule
